// File: rtl/uart_axis_pkg.sv
// uart_axis_pkg: shared frame constants, FSM state type and bit-period helper for uart_axis
package uart_axis_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int OVERSAMPLE = 8;
  localparam int IDX_W = $clog2(DATA_WIDTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
  function automatic logic [18:0] bit_period(input logic [15:0] ps);
    return 19'(ps == 16'd0 ? 16'd1 : ps) * 19'(OVERSAMPLE);
  endfunction
endpackage

// File: rtl/uart_axis_rx.sv
// uart_axis_rx: input synchroniser, 8N1 receive FSM and m_axis holding register
module uart_axis_rx
  import uart_axis_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  input  logic [15:0]           prescale,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);
  logic [1:0] sync_q;
  logic prev_q, rx_s, tick, good;
  uart_state_e st_q, st_d;
  logic [18:0] cnt_q, cnt_d, per_q, per_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  assign rx_s = sync_q[1];
  assign tick = cnt_q == '0;
  // next state: first timeout after the start edge lands mid-bit, later ones one bit apart
  always_comb begin
    st_d = st_q;
    cnt_d = tick ? per_q - 19'd1 : cnt_q - 19'd1;
    per_d = per_q;
    sh_d = sh_q;
    idx_d = idx_q;
    good = 1'b0;
    case (st_q)
      IDLE: if (prev_q && !rx_s) begin
        st_d = START;
        per_d = bit_period(prescale);
        cnt_d = (bit_period(prescale) >> 1) - 19'd1;
      end
      START: if (tick) begin
        st_d = rx_s ? IDLE : DATA;
        idx_d = '0;
      end
      DATA: if (tick) begin
        sh_d = {rx_s, sh_q[DATA_WIDTH-1:1]};
        idx_d = idx_q + IDX_W'(1);
        st_d = idx_q == IDX_W'(DATA_WIDTH - 1) ? STOP : DATA;
      end
      STOP: if (tick) begin
        st_d = IDLE;
        good = rx_s;
      end
    endcase
  end
  // state, synchroniser and output register; a new good byte beats a same-cycle handshake
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      st_q <= IDLE;
      cnt_q <= '0;
      per_q <= 19'(OVERSAMPLE);
      sh_q <= '0;
      idx_q <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= rx_s;
      st_q <= st_d;
      cnt_q <= cnt_d;
      per_q <= per_d;
      sh_q <= sh_d;
      idx_q <= idx_d;
      m_axis_tvalid <= good || (m_axis_tvalid && !m_axis_tready);
      m_axis_tdata <= good ? sh_q : m_axis_tdata;
    end
  end
endmodule

// File: rtl/uart_axis.sv
// uart_axis: full-duplex 8N1 UART with AXI-Stream byte ports; define UART_LOOPBACK_EN to feed TX_o into the receiver
module uart_axis
  import uart_axis_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  RX_i,
  output logic                  TX_o,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic [15:0]           prescale
);
  uart_state_e st_q, st_d;
  logic [18:0] cnt_q, cnt_d, per_q, per_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic tick, accept, tx_d, rdy_d, rx_in;
  assign tick = cnt_q == '0;
  assign accept = s_axis_tvalid && s_axis_tready;
`ifdef UART_LOOPBACK_EN
  logic unused_rx;
  assign unused_rx = RX_i;
  assign rx_in = TX_o;
`else
  assign rx_in = RX_i;
`endif
  // TX next state: each bit is held for one latched bit period, shifting LSB first
  always_comb begin
    st_d = st_q;
    cnt_d = tick ? per_q - 19'd1 : cnt_q - 19'd1;
    per_d = per_q;
    sh_d = sh_q;
    idx_d = idx_q;
    tx_d = TX_o;
    rdy_d = (st_q == IDLE && !accept) || (st_q == STOP && tick);
    case (st_q)
      IDLE: if (accept) begin
        st_d = START;
        per_d = bit_period(prescale);
        cnt_d = bit_period(prescale) - 19'd1;
        sh_d = s_axis_tdata;
        tx_d = 1'b0;
      end
      START: if (tick) begin
        st_d = DATA;
        idx_d = '0;
        tx_d = sh_q[0];
      end
      DATA: if (tick) begin
        sh_d = sh_q >> 1;
        idx_d = idx_q + IDX_W'(1);
        st_d = idx_q == IDX_W'(DATA_WIDTH - 1) ? STOP : DATA;
        tx_d = idx_q == IDX_W'(DATA_WIDTH - 1) || sh_q[1];
      end
      STOP: if (tick) st_d = IDLE;
    endcase
  end
  // TX state register; the line and tready are registered so reset forces them immediately
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q <= IDLE;
      cnt_q <= '0;
      per_q <= 19'(OVERSAMPLE);
      sh_q <= '0;
      idx_q <= '0;
      TX_o <= 1'b1;
      s_axis_tready <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      per_q <= per_d;
      sh_q <= sh_d;
      idx_q <= idx_d;
      TX_o <= tx_d;
      s_axis_tready <= rdy_d;
    end
  end
  uart_axis_rx u_rx (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .rx_i(rx_in),
    .prescale(prescale),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );
endmodule

// File: tb/tb_uart_axis.sv
// tb_uart_axis: checks uart_axis against a frame-timing model plus directed literal expectations
module tb_uart_axis;
  logic clk = 0, rst_n = 0, rx_drv = 1, loop = 0;
  logic rx_pin, tx, s_tready, m_tvalid;
  logic s_tvalid = 0, m_tready = 0;
  logic [7:0] s_tdata = 0, m_tdata;
  logic [15:0] prescale = 16'd4;
  int cyc = 0, n_chk = 0, n_fail = 0;
  bit hist [0:32767];
  bit started = 0, acc_ok = 0, rx_busy = 0;
  logic e_tx = 1, e_rdy = 0, ev = 0;
  logic [7:0] ed = 0, ab = 0;
  int acc = 0, at = 8, rf = 0, rt = 8, search_from = 0, t0 = 0, t1 = 0;
  bit bits1 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  assign rx_pin = loop ? tx : rx_drv;
  always #5 clk = ~clk;
  uart_axis dut (
    .clk_i(clk), .rst_ni(rst_n), .RX_i(rx_pin), .TX_o(tx),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .prescale(prescale)
  );
  function automatic int bit_time(input logic [15:0] p);
    return (p == 16'd0 ? 1 : int'(p)) * 8;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask
  // line value that the next rising edge will sample
  always @(negedge clk) if (cyc < 32767) hist[cyc + 1] = rx_pin;
  // model: TX waveform from accept time, RX decode from the line history at bit centres
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      started = 1; acc_ok = 0; e_tx = 1; e_rdy = 0;
      rx_busy = 0; ev = 0; ed = 0; search_from = cyc + 3;
    end else begin
      if (s_tvalid && e_rdy) begin
        acc_ok = 1; acc = cyc; ab = s_tdata; at = bit_time(prescale);
      end
      if (acc_ok && cyc - acc < 10 * at) begin
        int b;
        b = (cyc - acc) / at;
        e_tx = b == 0 ? 1'b0 : b == 9 ? 1'b1 : ab[b - 1];
        e_rdy = 0;
      end else begin
        e_tx = 1; e_rdy = 1;
      end
      if (ev && m_tready) ev = 0;
      if (rx_busy) begin
        if (cyc == rf + 2 + rt / 2 && hist[rf + rt / 2]) rx_busy = 0;
        else if (cyc == rf + 2 + rt / 2 + 9 * rt) begin
          rx_busy = 0;
          if (hist[rf + rt / 2 + 9 * rt]) begin
            ev = 1;
            for (int k = 0; k < 8; k++) ed[k] = hist[rf + rt / 2 + (k + 1) * rt];
          end
        end
      end else if (cyc >= search_from && hist[cyc - 3] && !hist[cyc - 2]) begin
        rx_busy = 1; rf = cyc - 2; rt = bit_time(prescale);
      end
    end
  end
  // per-cycle comparison against the model
  always @(negedge clk) if (started) begin
    chk("model_tx_o", 32'(tx), 32'(e_tx));
    chk("model_s_tready", 32'(s_tready), 32'(e_rdy));
    chk("model_m_tvalid", 32'(m_tvalid), 32'(ev));
    chk("model_m_tdata", 32'(m_tdata), 32'(ed));
  end
  always @(posedge clk) if (cyc > 30000) begin
    $display("FAIL watchdog: cycle limit reached");
    $fatal(1, "watchdog");
  end
  task automatic wait_ready(input string name);
    int n = 0;
    while (!s_tready && n < 2000) begin @(negedge clk); n++; end
    chk(name, 32'(s_tready), 32'd1);
  endtask
  task automatic wait_mvalid(input string name);
    int n = 0;
    while (!m_tvalid && n < 1000) begin @(negedge clk); n++; end
    chk(name, 32'(m_tvalid), 32'd1);
  endtask
  task automatic tx_send(input logic [7:0] d);
    @(negedge clk);
    wait_ready("tx_send_ready");
    s_tdata = d; s_tvalid = 1;
    @(negedge clk);
    s_tvalid = 0;
  endtask
  task automatic rx_send(input logic [7:0] d, input logic stop);
    int t;
    logic [9:0] f;
    t = bit_time(prescale);
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin rx_drv = f[i]; repeat (t) @(negedge clk); end
    rx_drv = 1;
  endtask
  task automatic consume();
    m_tready = 1;
    @(negedge clk);
    m_tready = 0;
  endtask
  initial begin
    for (int i = 0; i < 32768; i++) hist[i] = 1;
    repeat (3) @(negedge clk);
    chk("rst_tx_o", 32'(tx), 32'd1);
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'h00);
    rst_n = 1;
    @(negedge clk);
    chk("rst_release_tready", 32'(s_tready), 32'd1);
    // 1: loopback A5 at prescale 4, bit centres every 32 clocks
    loop = 1;
    tx_send(8'hA5);
    repeat (16) @(negedge clk);
    chk("t1_start_bit", 32'(tx), 32'd0);
    for (int b = 0; b < 8; b++) begin
      repeat (32) @(negedge clk);
      chk("t1_data_bit", 32'(tx), 32'(bits1[b]));
    end
    repeat (32) @(negedge clk);
    chk("t1_stop_bit", 32'(tx), 32'd1);
    wait_mvalid("t1_rx_valid");
    chk("t1_rx_data", 32'(m_tdata), 32'hA5);
    consume();
    wait_ready("t1_idle");
    loop = 0;
    // 2: back-to-back accepts with tvalid held
    @(negedge clk);
    s_tdata = 8'h00; s_tvalid = 1;
    wait_ready("t2_first_ready");
    t0 = cyc + 1;
    @(negedge clk);
    s_tdata = 8'hFF;
    wait_ready("t2_second_ready");
    t1 = cyc + 1;
    @(negedge clk);
    s_tvalid = 0;
    chk("t2_accept_spacing", 32'(t1 - t0), 32'd321);
    wait_ready("t2_idle");
    // 3: 10-clock glitch ignored, then 3C received
    @(negedge clk);
    rx_drv = 0;
    repeat (10) @(negedge clk);
    rx_drv = 1;
    repeat (64) @(negedge clk);
    chk("t3_glitch_no_valid", 32'(m_tvalid), 32'd0);
    rx_send(8'h3C, 1'b1);
    wait_mvalid("t3_rx_valid");
    chk("t3_rx_data", 32'(m_tdata), 32'h3C);
    consume();
    // 4: framing error discards 81
    rx_send(8'h81, 1'b0);
    repeat (64) @(negedge clk);
    chk("t4_framing_no_valid", 32'(m_tvalid), 32'd0);
    // 5: overrun keeps tvalid and latest byte
    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    chk("t5_overrun_valid", 32'(m_tvalid), 32'd1);
    chk("t5_overrun_data", 32'(m_tdata), 32'h22);
    consume();
    chk("t5_cleared", 32'(m_tvalid), 32'd0);
    // 6: reset in the middle of a TX frame
    tx_send(8'h5A);
    repeat (100) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("t6_rst_tx_o", 32'(tx), 32'd1);
    chk("t6_rst_tready", 32'(s_tready), 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("t6_release_tready", 32'(s_tready), 32'd1);
    loop = 1;
    tx_send(8'hC3);
    wait_mvalid("t6_rx_valid");
    chk("t6_rx_data", 32'(m_tdata), 32'hC3);
    consume();
    wait_ready("t6_idle");
    // 7: prescale 0 acts as 1; changing prescale mid-frame has no effect
    prescale = 16'd0;
    tx_send(8'h96);
    repeat (10) @(negedge clk);
    prescale = 16'd2;
    wait_mvalid("t7_rx_valid");
    chk("t7_rx_data", 32'(m_tdata), 32'h96);
    consume();
    wait_ready("t7_idle");
    loop = 0;
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
